onehot_scan_decoder: RTL
========================

# onehot_scan_decoder

Registered, parametrised N-output one-hot decoder (N = 2^SEL_W) with enable, supporting two modes: direct decode of a supplied index, and auto-scan that steps the active output through 0..last with a programmable dwell time. It drives display-digit multiplexing and keypad-column strobing, replacing the fixed combinational 4-to-16 decode tree.

## Interface
Parameters:
- SEL_W, default 4: index width; N = 2^SEL_W outputs.
- DWELL_W, default 8: dwell counter width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  enable; 0 forces all outputs low.
- mode  in  1  0 = direct, 1 = scan.
- sel  in  SEL_W  direct-mode index.
- sel_valid  in  1  loads sel in direct mode.
- last  in  SEL_W  highest index visited in scan mode.
- dwell  in  DWELL_W  cycles per scan position, minus one.
- onehot  out  N  bit k high iff active index is k.
- idx  out  SEL_W  current active index.
- wrap  out  1  one-cycle pulse on scan wrap last->0.

## Operation
- Reset (rst_n low, asynchronous): onehot = 0, idx = 0, wrap = 0, dwell counter = 0, state = IDLE.
- States: IDLE (onehot all zero), DIRECT, SCAN.
- In any state, en = 0 -> next state IDLE; onehot = 0; idx held; counter cleared; wrap = 0.
- From IDLE, en = 1 and mode = 0 -> DIRECT.
  - onehot stays 0 until the first sel_valid.
  - Then onehot = 1<<sel.
- From IDLE, en = 1 and mode = 1 -> SCAN, starting at idx 0.
- DIRECT:
  - sel_valid = 1 -> idx <= sel, onehot <= 1<<sel.
  - Otherwise hold.
- SCAN:
  - Counter increments each cycle.
  - When counter >= dwell: counter <= 0 and idx advances.
  - If idx >= last, idx <= 0 and wrap pulses high for one cycle, coincident with the new onehot.
  - dwell = 0 -> advance every cycle.
  - last = 0 -> idx stays 0; wrap pulses every dwell+1 cycles.
  - sel_valid is ignored.
- Mode 1->0 while enabled: go to DIRECT.
  - Current idx/onehot held until sel_valid.
  - Counter cleared; no wrap.
- Mode 0->1 while enabled: go to SCAN.
  - idx <= 0, onehot <= 1 at the next edge.
  - Counter cleared.
- last or dwell changed mid-scan: applied live at the next comparison. If idx > last, the next advance wraps to 0.
- Invariant: onehot is either all-zero or has exactly one bit set, equal to 1<<idx whenever non-zero.

## Timing
- All outputs registered; no combinational input->output path.
- Direct latency: sel_valid at edge t -> onehot/idx updated after edge t (visible cycle t+1).
- Scan period per position: dwell+1 cycles. Full sweep: (last+1)*(dwell+1) cycles.
- en deassert: onehot = 0 one cycle later. en reassert in SCAN mode: scan restarts at index 0.
- wrap: exactly one cycle wide, never asserted outside SCAN.
- Reset mid-scan: outputs clear immediately; resume from IDLE after rst_n release.

## Structure
- Shared package:
  - state enum IDLE/DIRECT/SCAN (2-bit)
  - mode constants MODE_DIRECT = 0, MODE_SCAN = 1
- Sub-module onehot_dec: purely combinational, parametrised by SEL_W, index -> N-bit one-hot. Instantiated once, feeding the onehot register.
- Top-level holds the FSM, dwell counter, idx register and wrap register.

## Test plan
- Reset then direct, en = 1, mode = 0, sel_valid with sel = 5 (SEL_W = 4) -> next cycle onehot = 0x0020 (bit 5), idx = 5; onehot holds with sel_valid low.
- Scan, last = 3, dwell = 2 -> idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. wrap high only in the first cycle of the return to 0; period 12 cycles.
- en dropped for 2 cycles mid-scan at idx 2 -> onehot = 0 next cycle. Re-enabled -> scan restarts at idx 0 with the counter cleared.
- Scan, dwell = 0, last lowered from 7 to 2 while idx = 5 -> next cycle idx = 0 with a wrap pulse.
- Mode 1->0 at idx 3 -> onehot holds bit 3 until sel_valid with sel = 9 -> bit 9. sel_valid asserted in scan mode has no effect.
- rst_n asserted asynchronously mid-cycle during scan -> onehot, idx and wrap go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/onehot_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : onehot_scan_decoder_pkg
// Description : Shared types and constants for the one-hot scan decoder.
//               Provides the controller state encoding and the mode values.
// Revision    : 1.0 - initial release
// ============================================================================
package onehot_scan_decoder_pkg;

  // Controller state: IDLE drives all-zero, DIRECT follows sel loads,
  // SCAN steps the active index autonomously.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/onehot_scan_decoder_dec.sv
`default_nettype none
// ============================================================================
// Module      : onehot_dec
// Description : Purely combinational index -> one-hot decoder.
// Ports       : idx    in  SEL_W       index to decode
//               onehot out 2**SEL_W    bit idx set, all others clear
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_dec
  import onehot_scan_decoder_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [(1<<SEL_W)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule
`default_nettype wire

// File: rtl/onehot_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : onehot_scan_decoder
// Description : Registered N-output one-hot decoder (N = 2**SEL_W) with
//               enable. Direct mode decodes a loaded index; scan mode steps
//               the active output through 0..last, dwell+1 cycles per step.
// Ports       : clk       in  1        system clock, rising edge
//               rst_n     in  1        asynchronous active-low reset
//               en        in  1        enable; 0 forces outputs low
//               mode      in  1        0 = direct, 1 = scan
//               sel       in  SEL_W    direct-mode index
//               sel_valid in  1        loads sel in direct mode
//               last      in  SEL_W    highest index visited in scan
//               dwell     in  DWELL_W  cycles per scan position minus one
//               onehot    out N        one-hot of the active index (or 0)
//               idx       out SEL_W    current active index
//               wrap      out 1        one-cycle pulse on scan wrap to 0
// Revision    : 1.0 - initial release
// ============================================================================
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int SEL_W   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      last,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] onehot,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] c_FIRST = {{(N-1){1'b0}}, 1'b1};

  state_t             r_state;
  logic [DWELL_W-1:0] r_cnt;

  logic               w_at_end;
  logic [SEL_W-1:0]   w_scan_next;
  logic [SEL_W-1:0]   w_dec_idx;
  logic [N-1:0]       w_dec_onehot;

  // ">=" rather than "==" so a last lowered below the current index still
  // wraps on the next advance instead of running up to the top.
  assign w_at_end    = (idx >= last);
  assign w_scan_next = w_at_end ? '0 : idx + SEL_W'(1);

  // A single decoder serves both modes: in SCAN it decodes the next scan
  // position, otherwise the externally supplied index.
  assign w_dec_idx = (r_state == SCAN) ? w_scan_next : sel;

  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .idx    (w_dec_idx),
    .onehot (w_dec_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      onehot  <= '0;
      idx     <= '0;
      wrap    <= 1'b0;
    end else if (!en) begin
      // idx is deliberately held so a later direct entry still reports it.
      r_state <= IDLE;
      r_cnt   <= '0;
      onehot  <= '0;
      wrap    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      case (r_state)
        IDLE, DIRECT: begin
          r_cnt <= '0;
          if (mode == MODE_SCAN) begin
            r_state <= SCAN;
            idx     <= '0;
            onehot  <= c_FIRST;
          end else begin
            // Leaving IDLE the onehot register is already zero, so the
            // outputs stay dark until the first sel_valid.
            r_state <= DIRECT;
            if (sel_valid) begin
              idx    <= sel;
              onehot <= w_dec_onehot;
            end
          end
        end
        SCAN: begin
          if (mode == MODE_DIRECT) begin
            r_state <= DIRECT;
            r_cnt   <= '0;
          end else if (r_cnt >= dwell) begin
            r_cnt  <= '0;
            idx    <= w_scan_next;
            onehot <= w_dec_onehot;
            wrap   <= w_at_end;
          end else begin
            r_cnt <= r_cnt + DWELL_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          onehot  <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
